// File: rtl/cpu_sram_bus_bridge_pkg.sv
// Shared definitions for the CPU-to-SRAM-style bus bridge: FSM states,
// transaction owner encoding, one-hot grant codes and the address width default.
package cpu_sram_bus_bridge_pkg;

    localparam int ADDR_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } bridge_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    // Grant vector layout: bit 0 = inst port, bit 1 = data port
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_INST = 2'b01;
    localparam logic [1:0] GRANT_DATA = 2'b10;

    // The port that should be favoured after the given owner was served
    function automatic owner_t other_owner(input owner_t served);
        return (served == OWN_INST) ? OWN_DATA : OWN_INST;
    endfunction

endpackage

// File: rtl/bridge_arb.sv
// Two-way arbiter between the instruction and data request ports.
// RR_EN=1 lets the pointer decide simultaneous requests; RR_EN=0 makes data
// win every tie. No grant is produced while enable is low.
module bridge_arb
    import cpu_sram_bus_bridge_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic       inst_req,
    input  logic       data_req,
    input  logic       rr_ptr,
    input  logic       enable,
    output logic [1:0] grant
);

    // Pick at most one requester; ties go to the pointer or to data
    always_comb begin
        grant = GRANT_NONE;
        if (enable) begin
            if (inst_req && data_req) begin
                if (RR_EN && (rr_ptr == OWN_INST)) begin
                    grant = GRANT_INST;
                end else begin
                    grant = GRANT_DATA;
                end
            end else if (data_req) begin
                grant = GRANT_DATA;
            end else if (inst_req) begin
                grant = GRANT_INST;
            end
        end
    end

endmodule

// File: rtl/cpu_sram_bus_bridge.sv
// Bridges a CPU's separate instruction-fetch and load/store request ports onto
// one single-outstanding memory bus. Define BRIDGE_RR_ARB_EN for round-robin
// arbitration; by default data requests win over instruction fetches.
module cpu_sram_bus_bridge
    import cpu_sram_bus_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

`ifdef BRIDGE_RR_ARB_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    // Clears the two byte-offset bits so the bus always sees word addresses
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    bridge_state_t     state;
    bridge_state_t     state_next;
    logic [1:0]        grant;
    logic              arb_en;
    owner_t            owner_q;
    owner_t            rr_ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    // New requests are only considered when the bus is free and out of reset
    assign arb_en = resetn && (state == IDLE);

    bridge_arb #(
        .RR_EN (RR_EN)
    ) u_arb (
        .inst_req (inst_req),
        .data_req (data_req),
        .rr_ptr   (rr_ptr_q),
        .enable   (arb_en),
        .grant    (grant)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept, hold the bus request, wait for read data, respond
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant != GRANT_NONE) state_next = REQ;
            REQ:     if (mem_ready) state_next = wr_q ? RESP : WAIT_R;
            WAIT_R:  if (mem_rvalid) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: handshakes decoded from state, bus fields from the latched request
    always_comb begin
        inst_addr_ok = grant[0];
        data_addr_ok = grant[1];
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wstrb    = 4'b0000;
        mem_wdata    = 32'd0;
        inst_rdata   = 32'd0;
        data_rdata   = 32'd0;
        if (resetn) begin
            mem_req      = (state == REQ);
            inst_data_ok = (state == RESP) && (owner_q == OWN_INST);
            data_data_ok = (state == RESP) && (owner_q == OWN_DATA);
            mem_wr       = wr_q;
            mem_addr     = addr_q;
            mem_wstrb    = wstrb_q;
            mem_wdata    = wdata_q;
            inst_rdata   = rdata_q;
            data_rdata   = rdata_q;
        end
    end

    // Latch the granted request, advance the pointer, capture read data
    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner_q  <= OWN_INST;
            rr_ptr_q <= OWN_INST;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wstrb_q  <= 4'b0000;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            if (grant == GRANT_DATA) begin
                owner_q  <= OWN_DATA;
                rr_ptr_q <= other_owner(OWN_DATA);
                addr_q   <= data_addr & ALIGN_MASK;
                wr_q     <= data_wr;
                wstrb_q  <= data_wr ? data_wstrb : 4'b0000;
                wdata_q  <= data_wdata;
            end else if (grant == GRANT_INST) begin
                owner_q  <= OWN_INST;
                rr_ptr_q <= other_owner(OWN_INST);
                addr_q   <= inst_addr & ALIGN_MASK;
                wr_q     <= 1'b0;
                wstrb_q  <= 4'b0000;
                wdata_q  <= 32'd0;
            end
            if ((state == WAIT_R) && mem_rvalid) begin
                rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sram_bus_bridge.sv
// Self-checking bench for cpu_sram_bus_bridge. A transaction-level model predicts
// grants, handshake timing, bus fields and read data; a simple memory slave with
// programmable ready/rvalid delays and stray rvalid pulses sits on the bus.
module tb_cpu_sram_bus_bridge;

    localparam int ADDR_W = 32;
`ifdef BRIDGE_RR_ARB_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    cpu_sram_bus_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } busTxn_t;

    busTxn_t     expBus[$];
    logic [31:0] refMem [logic [29:0]];

    // Slave state
    int          readyDelay;
    int          rvalidDelay;
    int          reqCycles;
    int          rvCnt;
    bit          pending;
    bit          stray;
    logic [31:0] rdWord;
    logic [31:0] slvData [64];
    bit          slvValid [64];

    // Model state
    bit          busy;
    int          k;
    int          expLat;
    int          txnRdy;
    bit          expOwnerData;
    bit          expRead;
    logic [31:0] expRdata;
    bit          rrPtrData;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Power-on memory contents; the boot vector holds a fixed instruction
    function automatic logic [31:0] initWord(input logic [31:0] a);
        if (a[31:2] == 30'h2FF0_0001) return 32'h2408_0001;
        return {a[17:2] ^ 16'hC3A5, ~a[17:2]};
    endfunction

    function automatic logic [31:0] applyStrobe(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        return refMem.exists(a[31:2]) ? refMem[a[31:2]] : initWord(a);
    endfunction

    function automatic logic [31:0] slaveRead(input logic [31:0] a);
        return slvValid[a[7:2]] ? slvData[a[7:2]] : initWord(a);
    endfunction

    function automatic logic [1:0] expGrant(input logic i, input logic d, input bit ptrData);
        if (i && d) return (RR_MODE && !ptrData) ? 2'b01 : 2'b10;
        return {d, i};
    endfunction

    assign mem_ready  = mem_req && (reqCycles >= readyDelay);
    assign mem_rvalid = (pending && (rvCnt >= rvalidDelay)) || (stray && !pending);
    assign mem_rdata  = pending ? rdWord : 32'hDEAD_BEEF;

    // Bus slave: checks each accepted bus request, stores writes, schedules read data
    always @(posedge clk) begin
        if (!resetn) begin
            reqCycles <= 0;
            rvCnt     <= 0;
            pending   <= 1'b0;
        end else begin
            if (mem_req && mem_ready) begin
                reqCycles <= 0;
                checkOutput("bus_txn_expected", 32'(expBus.size() > 0), 32'd1);
                if (expBus.size() > 0) begin
                    checkOutput("bus_addr", mem_addr, expBus[0].addr);
                    checkOutput("bus_wr", 32'(mem_wr), 32'(expBus[0].wr));
                    checkOutput("bus_wstrb", 32'(mem_wstrb), 32'(expBus[0].wstrb));
                    if (expBus[0].wr) checkOutput("bus_wdata", mem_wdata, expBus[0].wdata);
                    void'(expBus.pop_front());
                end
                if (mem_wr) begin
                    slvData[mem_addr[7:2]]  <= applyStrobe(slaveRead(mem_addr), mem_wdata, mem_wstrb);
                    slvValid[mem_addr[7:2]] <= 1'b1;
                end else begin
                    pending <= 1'b1;
                    rvCnt   <= 0;
                    rdWord  <= slaveRead(mem_addr);
                end
            end else if (mem_req) begin
                reqCycles <= reqCycles + 1;
            end
            if (pending) begin
                if (mem_rvalid) pending <= 1'b0;
                else rvCnt <= rvCnt + 1;
            end
        end
    end

    task automatic applyStimulus(input bit iReq, input logic [31:0] iAddr, input bit dReq, input bit dWr,
                                 input logic [3:0] dStrb, input logic [31:0] dAddr, input logic [31:0] dWdata);
        inst_req   = iReq;
        inst_addr  = iAddr;
        data_req   = dReq;
        data_wr    = dWr;
        data_wstrb = dStrb;
        data_addr  = dAddr;
        data_wdata = dWdata;
    endtask

    // One clock of observation against the transaction model; returns at the next negedge
    task automatic stepCycle(output bit accepted, output bit done);
        logic [1:0]  g;
        logic [31:0] a;
        bit          rd;
        bit          dok;
        busTxn_t     t;
        accepted = 1'b0;
        done     = 1'b0;
        #1;
        if (busy) begin
            k++;
            checkOutput("addr_ok_busy", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
            checkOutput("mem_req", 32'(mem_req), 32'(k <= 1 + txnRdy));
            dok = (k == expLat);
            checkOutput("inst_data_ok", 32'(inst_data_ok), 32'(dok && !expOwnerData));
            checkOutput("data_data_ok", 32'(data_data_ok), 32'(dok && expOwnerData));
            if (dok && expRead) checkOutput("rdata", expOwnerData ? data_rdata : inst_rdata, expRdata);
            if (dok) begin
                busy = 1'b0;
                done = 1'b1;
            end
        end else begin
            g = expGrant(inst_req, data_req, rrPtrData);
            checkOutput("inst_addr_ok", 32'(inst_addr_ok), 32'(g[0]));
            checkOutput("data_addr_ok", 32'(data_addr_ok), 32'(g[1]));
            checkOutput("data_ok_idle", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
            checkOutput("mem_req_idle", 32'(mem_req), 32'd0);
            if (g != 2'b00) begin
                busy         = 1'b1;
                k            = 0;
                accepted     = 1'b1;
                expOwnerData = g[1];
                rd           = g[0] || !data_wr;
                expRead      = rd;
                a            = g[1] ? data_addr : inst_addr;
                txnRdy       = readyDelay;
                expLat       = rd ? 3 + readyDelay + rvalidDelay : 2 + readyDelay;
                if (rd) expRdata = refRead(a);
                else refMem[a[31:2]] = applyStrobe(refRead(a), data_wdata, data_wstrb);
                t.addr  = a & 32'hFFFF_FFFC;
                t.wr    = !rd;
                t.wstrb = rd ? 4'b0000 : data_wstrb;
                t.wdata = data_wdata;
                expBus.push_back(t);
                rrPtrData = !g[1];
            end
        end
        @(negedge clk);
    endtask

    task automatic runTxn(input bit iReq, input logic [31:0] iAddr, input bit dReq, input bit dWr,
                          input logic [3:0] dStrb, input logic [31:0] dAddr, input logic [31:0] dWdata,
                          input bit useStray);
        bit acc, acc2, done;
        int n;
        applyStimulus(iReq, iAddr, dReq, dWr, dStrb, dAddr, dWdata);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 10) begin
            stray = useStray && ($urandom_range(0, 7) == 0);
            stepCycle(acc, done);
            n++;
        end
        checkOutput("accept_in_time", 32'(acc), 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        done = 1'b0;
        n    = 0;
        while (acc && !done && n < 40) begin
            stray = useStray && ($urandom_range(0, 7) == 0);
            stepCycle(acc2, done);
            n++;
        end
        stray = 1'b0;
    endtask

    task automatic runHeld(input bit iOn, input bit dOn, input bit dWr, input int nTxn);
        bit acc, done;
        int cnt, n;
        applyStimulus(iOn, 32'h0040_0008, dOn, dWr, 4'b0011, 32'h0040_000C, $urandom);
        cnt = 0;
        n   = 0;
        while (cnt < nTxn && n < 100) begin
            stepCycle(acc, done);
            if (acc) cnt++;
            n++;
        end
        checkOutput("held_grant_count", cnt, nTxn);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        n = 0;
        while (busy && n < 40) begin
            stepCycle(acc, done);
            n++;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_addr_ok"}, {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        checkOutput({tag, "_data_ok"}, {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        checkOutput({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_inst_rdata"}, inst_rdata, 32'd0);
        checkOutput({tag, "_data_rdata"}, data_rdata, 32'd0);
    endtask

    initial begin
        bit          acc, done, iOn, dOn;
        logic [31:0] pa;
        resetn      = 1'b0;
        readyDelay  = 0;
        rvalidDelay = 0;
        stray       = 1'b0;
        busy        = 1'b0;
        rrPtrData   = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 checkAllZero("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Boot fetch with slow bus
        readyDelay  = 2;
        rvalidDelay = 2;
        runTxn(1'b1, 32'hBFC0_0004, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        stepCycle(acc, done);

        // Byte store to an unaligned address, then read it back
        readyDelay  = 0;
        rvalidDelay = 0;
        runTxn(1'b0, 32'd0, 1'b1, 1'b1, 4'b1000, 32'h8000_0003, 32'hAA00_0000, 1'b0);
        runTxn(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'h8000_0000, 32'd0, 1'b0);

        // Both ports held for four grants
        runHeld(1'b1, 1'b1, 1'b0, 4);

        // Data request held high across a long read
        rvalidDelay = 3;
        runHeld(1'b0, 1'b1, 1'b0, 2);

        // Randomized traffic with stray rvalid pulses
        for (int i = 0; i < 40; i++) begin
            readyDelay  = $urandom_range(0, 3);
            rvalidDelay = $urandom_range(0, 3);
            iOn = 1'($urandom_range(0, 1));
            dOn = iOn ? 1'($urandom_range(0, 1)) : 1'b1;
            pa  = 32'h1000_0040 + (32'($urandom_range(0, 15)) << 2);
            runTxn(iOn, pa + 32'($urandom_range(0, 3)), dOn, 1'($urandom_range(0, 1)),
                   4'($urandom_range(1, 15)), 32'h1000_0040 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3)),
                   $urandom, 1'b1);
        end

        // Reset in the middle of a read, then a stray rvalid
        readyDelay  = 0;
        rvalidDelay = 6;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'h0040_0010, 32'd0);
        stepCycle(acc, done);
        checkOutput("rst_txn_accept", 32'(acc), 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        stepCycle(acc, done);
        stepCycle(acc, done);
        resetn = 1'b0;
        #1 checkAllZero("in_reset");
        @(negedge clk);
        busy      = 1'b0;
        rrPtrData = 1'b0;
        expBus.delete();
        resetn    = 1'b1;
        stray     = 1'b1;
        stepCycle(acc, done);
        stray = 1'b0;
        for (int i = 0; i < 3; i++) stepCycle(acc, done);
        #1 checkAllZero("after_reset");
        @(negedge clk);

        // Normal operation resumes
        readyDelay  = 1;
        rvalidDelay = 1;
        runTxn(1'b1, 32'h1000_0044, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
